id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register that sits directly upstream of the ALU and feeds it.
//  Resolves operand forwarding from the EX, MEM and WB stages, muxes in the immediate,
//  and detects load-use hazards. It stalls decode and inserts a bubble when needed.
//  Registered outputs drive the ALU ports rs, rs_unsigned, rt, rt_unsigned, ALUOp and shamt.
// PARAMETERS
//  DATA_W   32  datapath width
//  REG_AW   5   register address width
// PORTS
//  clock            in   1       rising-edge clock
//  reset            in   1       asynchronous, active-high; clears all state
//  stall            in   1       global freeze: hold all registers
//  flush            in   1       squash the instruction entering EX (branch taken)
//  id_valid         in   1       decode slot holds a real instruction
//  id_rs_addr       in   5       source register A address
//  id_rt_addr       in   5       source register B address
//  id_rd_addr       in   5       destination address (already rt/rd-selected)
//  id_rs_data       in   32      register-file read A
//  id_rt_data       in   32      register-file read B
//  id_imm           in   32      extended immediate
//  id_use_imm       in   1       operand B = id_imm instead of rt
//  id_alu_op        in   4       ALU operation code (0000 = none)
//  id_shamt         in   5       shift amount
//  id_reg_write     in   1       instruction writes rd
//  id_mem_read      in   1       instruction is a load
//  ex_result        in   32      ALU result of the instruction now in EX
//  mem_reg_write    in   1       MEM-stage producer valid and writing
//  mem_rd           in   5       MEM-stage destination
//  mem_result       in   32      MEM-stage write data
//  wb_reg_write     in   1       WB-stage producer valid and writing
//  wb_rd            in   5       WB-stage destination
//  wb_result        in   32      WB-stage write data
//  ex_valid         out  1       EX slot holds a real instruction
//  ex_rs            out  32      ALU operand A (drives rs and rs_unsigned)
//  ex_rt            out  32      ALU operand B (drives rt and rt_unsigned)
//  ex_store_data    out  32      forwarded rt value, before the immediate mux
//  ex_alu_op        out  4       ALUOp
//  ex_shamt         out  5       shamt
//  ex_rd            out  5       destination
//  ex_reg_write     out  1       destination write enable
//  ex_mem_read      out  1       load flag
//  load_use_stall   out  1       combinational; hold PC and IF/ID this cycle
// BEHAVIOUR
//  - reset: every output register goes to 0 (bubble; ex_alu_op = 4'b0000).
//  - Latency: 1 cycle. Values presented in ID at edge N appear on ex_* after edge N.
//  - Forwarding, evaluated per source (A and B) independently, first match wins:
//    1. EX: ex_valid & ex_reg_write & !ex_mem_read & ex_rd==addr -> ex_result
//    2. MEM: mem_reg_write & mem_rd==addr -> mem_result
//    3. WB: wb_reg_write & wb_rd==addr -> wb_result
//    4. otherwise the register-file data.
//    Address 0 is never forwarded; $0 always reads id_*_data.
//  - Operand B: ex_rt = id_use_imm ? id_imm : fwdB. ex_store_data = fwdB always.
//  - load_use_stall = id_valid & ex_valid & ex_mem_read & ex_rd!=0 &
//    (ex_rd==id_rs_addr | ex_rd==id_rt_addr).
//  - Per-edge priority: reset > flush > stall > load_use bubble > load.
//    - flush: load a bubble (all zero), even when stall is asserted.
//    - stall (no flush): hold every register unchanged.
//    - load_use: load a bubble. ID is held upstream, so the next cycle re-evaluates
//      with the load now in MEM and forwards from mem_result.
//    - load: capture ID fields. ex_valid = id_valid. Control bits are gated by id_valid.
//  - Reset asserted mid-operation clears state immediately without waiting for a clock edge.
//    The first edge after release loads normally.
// TESTING
//  - Reset: assert with nonzero ID inputs -> all ex_* = 0 and load_use_stall = 0.
//  - EX forward: add $3 in EX, ex_result=0x10; ID add rs=$3, rf=0x99 -> next ex_rs=0x10.
//  - Priority: EX and MEM both target $5 (0xA, 0xB); ID rt=$5 -> ex_rt=0xA.
//    Repeat with EX invalid -> 0xB.
//  - $0: MEM writes rd=0 with 0xFFFF; ID rs=$0, rf=0 -> ex_rs=0.
//  - Load-use: lw $4 in EX; ID add rs=$4 -> stall=1 and bubble in EX.
//    Next cycle mem_result=0x77 -> ex_rs=0x77.
//  - flush with stall both high -> ex_valid=0, ex_reg_write=0, ex_alu_op=0000.
//  - Immediate: id_use_imm=1, imm=0xFFFFFFFC, rt forwarded 0x5 -> ex_rt=0xFFFFFFFC
//    and ex_store_data=0x5.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// Bundle between the decode stage, the downstream forwarding sources and the
// ID/EX operand register. The master side is decode/hazard logic; the slave side is the stage.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) ();
  // pipeline control
  logic              stall;
  logic              flush;

  // decode slot
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [REG_AW-1:0] id_rd_addr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic [3:0]        id_alu_op;
  logic [4:0]        id_shamt;
  logic              id_reg_write;
  logic              id_mem_read;

  // forwarding sources
  logic [DATA_W-1:0] ex_result;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_result;

  // EX slot towards the ALU
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs;
  logic [DATA_W-1:0] ex_rt;
  logic [DATA_W-1:0] ex_store_data;
  logic [3:0]        ex_alu_op;
  logic [4:0]        ex_shamt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              load_use_stall;

  modport master (
    output stall, flush,
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
    output id_imm, id_use_imm, id_alu_op, id_shamt, id_reg_write, id_mem_read,
    output ex_result, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    input  ex_valid, ex_rs, ex_rt, ex_store_data, ex_alu_op, ex_shamt,
    input  ex_rd, ex_reg_write, ex_mem_read, load_use_stall
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
    input  id_imm, id_use_imm, id_alu_op, id_shamt, id_reg_write, id_mem_read,
    input  ex_result, mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    output ex_valid, ex_rs, ex_rt, ex_store_data, ex_alu_op, ex_shamt,
    output ex_rd, ex_reg_write, ex_mem_read, load_use_stall
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register: forwards EX/MEM/WB results into both source operands,
// muxes the immediate onto operand B and inserts a bubble on a load-use hazard.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  id_ex_operand_stage_if.slave bus
);

  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_rs;
  logic [DATA_W-1:0] r_ex_rt;
  logic [DATA_W-1:0] r_ex_store_data;
  logic [3:0]        r_ex_alu_op;
  logic [4:0]        r_ex_shamt;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;

  logic              w_ex_fwd_en;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_opnd_b;
  logic              w_load_use;

  // Nearest producer wins; $0 is hardwired so it never takes a forwarded value.
  function automatic logic [DATA_W-1:0] forward(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_en,
    input logic [REG_AW-1:0] ex_rd,
    input logic [DATA_W-1:0] ex_res,
    input logic              mem_en,
    input logic [REG_AW-1:0] mem_rd,
    input logic [DATA_W-1:0] mem_res,
    input logic              wb_en,
    input logic [REG_AW-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_res
  );
    logic [DATA_W-1:0] sel;
    sel = rf_data;
    if (addr != '0) begin
      if (ex_en && (ex_rd == addr))
        sel = ex_res;
      else if (mem_en && (mem_rd == addr))
        sel = mem_res;
      else if (wb_en && (wb_rd == addr))
        sel = wb_res;
    end
    return sel;
  endfunction

  // A load in EX has no data yet, so only ALU results forward from EX.
  assign w_ex_fwd_en = r_ex_valid & r_ex_reg_write & ~r_ex_mem_read;

  always_comb begin
    w_fwd_a = forward(bus.id_rs_addr, bus.id_rs_data,
                      w_ex_fwd_en, r_ex_rd, bus.ex_result,
                      bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                      bus.wb_reg_write, bus.wb_rd, bus.wb_result);
    w_fwd_b = forward(bus.id_rt_addr, bus.id_rt_data,
                      w_ex_fwd_en, r_ex_rd, bus.ex_result,
                      bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                      bus.wb_reg_write, bus.wb_rd, bus.wb_result);
    w_opnd_b = bus.id_use_imm ? bus.id_imm : w_fwd_b;
  end

  assign w_load_use = bus.id_valid & r_ex_valid & r_ex_mem_read & (r_ex_rd != '0) &
                      ((r_ex_rd == bus.id_rs_addr) | (r_ex_rd == bus.id_rt_addr));

  // ID -> EX register: flush beats stall, stall beats the load-use bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex_valid      <= 1'b0;
      r_ex_rs         <= '0;
      r_ex_rt         <= '0;
      r_ex_store_data <= '0;
      r_ex_alu_op     <= '0;
      r_ex_shamt      <= '0;
      r_ex_rd         <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
    end else if (bus.flush || (!bus.stall && w_load_use)) begin
      r_ex_valid      <= 1'b0;
      r_ex_rs         <= '0;
      r_ex_rt         <= '0;
      r_ex_store_data <= '0;
      r_ex_alu_op     <= '0;
      r_ex_shamt      <= '0;
      r_ex_rd         <= '0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
    end else if (!bus.stall) begin
      r_ex_valid      <= bus.id_valid;
      r_ex_rs         <= w_fwd_a;
      r_ex_rt         <= w_opnd_b;
      r_ex_store_data <= w_fwd_b;
      r_ex_alu_op     <= bus.id_valid ? bus.id_alu_op : 4'b0000;
      r_ex_shamt      <= bus.id_shamt;
      r_ex_rd         <= bus.id_rd_addr;
      r_ex_reg_write  <= bus.id_valid & bus.id_reg_write;
      r_ex_mem_read   <= bus.id_valid & bus.id_mem_read;
    end
  end

  assign bus.ex_valid       = r_ex_valid;
  assign bus.ex_rs          = r_ex_rs;
  assign bus.ex_rt          = r_ex_rt;
  assign bus.ex_store_data  = r_ex_store_data;
  assign bus.ex_alu_op      = r_ex_alu_op;
  assign bus.ex_shamt       = r_ex_shamt;
  assign bus.ex_rd          = r_ex_rd;
  assign bus.ex_reg_write   = r_ex_reg_write;
  assign bus.ex_mem_read    = r_ex_mem_read;
  assign bus.load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: forwarding priority, $0, load-use bubble,
// flush/stall ordering, immediate mux and asynchronous reset.
module tb_id_ex_operand_stage;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0;
    bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_use_imm = 0;
    bus.id_alu_op = 0; bus.id_shamt = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.ex_result = 0; bus.mem_reg_write = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_result = 0;
  endtask

  // Put an ALU instruction in the ID slot.
  task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_d, input logic [31:0] rt_d,
                          input logic wr, input logic ld);
    bus.id_valid = 1; bus.id_rs_addr = rs; bus.id_rt_addr = rt; bus.id_rd_addr = rd;
    bus.id_rs_data = rs_d; bus.id_rt_data = rt_d; bus.id_alu_op = 4'h2;
    bus.id_shamt = 5'd0; bus.id_reg_write = wr; bus.id_mem_read = ld; bus.id_use_imm = 0;
  endtask

  task automatic test_reset();
    id_instr(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 1, 1);
    bus.id_shamt = 5'd7; bus.id_imm = 32'h55;
    rst = 1;
    step();
    step();
    n_vec++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl got v=%b w=%b m=%b exp 0 0 0",
                        bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read);
    end
    n_vec++;
    if (bus.ex_rs !== 32'h0 || bus.ex_rt !== 32'h0 || bus.ex_store_data !== 32'h0 ||
        bus.ex_alu_op !== 4'h0 || bus.ex_shamt !== 5'h0 || bus.ex_rd !== 5'h0) begin
      n_err++; $display("FAIL reset_data got rs=%h rt=%h sd=%h op=%h sh=%h rd=%h exp all 0",
                        bus.ex_rs, bus.ex_rt, bus.ex_store_data, bus.ex_alu_op,
                        bus.ex_shamt, bus.ex_rd);
    end
    n_vec++;
    if (bus.load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL reset_lus got %b exp 0", bus.load_use_stall);
    end
    rst = 0;
    idle_inputs();
    step();
  endtask

  task automatic test_ex_forward();
    id_instr(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1, 0);
    step();
    id_instr(5'd3, 5'd0, 5'd9, 32'h99, 32'h0, 1, 0);
    bus.ex_result = 32'h10;
    #1;
    n_vec++;
    if (bus.load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL exfwd_lus got %b exp 0", bus.load_use_stall);
    end
    step();
    n_vec++;
    if (bus.ex_rs !== 32'h10 || bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd9) begin
      n_err++; $display("FAIL exfwd_rs got rs=%h v=%b rd=%0d exp rs=00000010 v=1 rd=9",
                        bus.ex_rs, bus.ex_valid, bus.ex_rd);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_priority();
    id_instr(5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1, 0);
    step();
    id_instr(5'd0, 5'd5, 5'd7, 32'h0, 32'h33, 1, 0);
    bus.ex_result = 32'hA;
    bus.mem_reg_write = 1; bus.mem_rd = 5'd5; bus.mem_result = 32'hB;
    bus.wb_reg_write = 1; bus.wb_rd = 5'd5; bus.wb_result = 32'hC;
    step();
    n_vec++;
    if (bus.ex_rt !== 32'hA || bus.ex_store_data !== 32'hA) begin
      n_err++; $display("FAIL prio_ex got rt=%h sd=%h exp 0000000a", bus.ex_rt, bus.ex_store_data);
    end
    // EX slot now holds a non-matching rd=7, then a bubble
    bus.id_valid = 0;
    step();
    id_instr(5'd0, 5'd5, 5'd7, 32'h0, 32'h33, 1, 0);
    step();
    n_vec++;
    if (bus.ex_rt !== 32'hB) begin
      n_err++; $display("FAIL prio_mem got %h exp 0000000b", bus.ex_rt);
    end
    bus.mem_reg_write = 0;
    step();
    n_vec++;
    if (bus.ex_rt !== 32'hC) begin
      n_err++; $display("FAIL prio_wb got %h exp 0000000c", bus.ex_rt);
    end
    bus.wb_reg_write = 0;
    step();
    n_vec++;
    if (bus.ex_rt !== 32'h33) begin
      n_err++; $display("FAIL prio_rf got %h exp 00000033", bus.ex_rt);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_zero_reg();
    id_instr(5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 1, 0);
    step();
    id_instr(5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 1, 0);
    bus.ex_result = 32'h1234;
    bus.mem_reg_write = 1; bus.mem_rd = 5'd0; bus.mem_result = 32'hFFFF;
    bus.wb_reg_write = 1; bus.wb_rd = 5'd0; bus.wb_result = 32'h5A5A;
    step();
    n_vec++;
    if (bus.ex_rs !== 32'h0 || bus.ex_rt !== 32'h0) begin
      n_err++; $display("FAIL zero_reg got rs=%h rt=%h exp 0 0", bus.ex_rs, bus.ex_rt);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_load_use();
    id_instr(5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 1, 1);
    step();
    id_instr(5'd4, 5'd2, 5'd6, 32'h11, 32'h22, 1, 0);
    bus.ex_result = 32'hDEAD;
    #1;
    n_vec++;
    if (bus.load_use_stall !== 1'b1) begin
      n_err++; $display("FAIL lu_stall got %b exp 1", bus.load_use_stall);
    end
    step();
    n_vec++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_alu_op !== 4'h0 ||
        bus.ex_mem_read !== 1'b0) begin
      n_err++; $display("FAIL lu_bubble got v=%b w=%b op=%h m=%b exp 0 0 0 0",
                        bus.ex_valid, bus.ex_reg_write, bus.ex_alu_op, bus.ex_mem_read);
    end
    bus.mem_reg_write = 1; bus.mem_rd = 5'd4; bus.mem_result = 32'h77;
    #1;
    n_vec++;
    if (bus.load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL lu_release got %b exp 0", bus.load_use_stall);
    end
    step();
    n_vec++;
    if (bus.ex_rs !== 32'h77 || bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin
      n_err++; $display("FAIL lu_fwd got rs=%h v=%b rd=%0d exp rs=00000077 v=1 rd=6",
                        bus.ex_rs, bus.ex_valid, bus.ex_rd);
    end
    // load into $0 never stalls; load on rt side does
    idle_inputs();
    id_instr(5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 1, 1);
    step();
    id_instr(5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 1, 0);
    #1;
    n_vec++;
    if (bus.load_use_stall !== 1'b0) begin
      n_err++; $display("FAIL lu_zero got %b exp 0", bus.load_use_stall);
    end
    id_instr(5'd1, 5'd0, 5'd12, 32'h0, 32'h0, 1, 1);
    step();
    id_instr(5'd3, 5'd12, 5'd6, 32'h0, 32'h0, 1, 0);
    #1;
    n_vec++;
    if (bus.load_use_stall !== 1'b1) begin
      n_err++; $display("FAIL lu_rt got %b exp 1", bus.load_use_stall);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_stall_flush();
    id_instr(5'd1, 5'd2, 5'd10, 32'hAB, 32'hCD, 1, 0);
    step();
    id_instr(5'd3, 5'd4, 5'd11, 32'h12, 32'h34, 1, 1);
    bus.stall = 1;
    step();
    n_vec++;
    if (bus.ex_rs !== 32'hAB || bus.ex_rt !== 32'hCD || bus.ex_rd !== 5'd10 ||
        bus.ex_valid !== 1'b1 || bus.ex_mem_read !== 1'b0) begin
      n_err++; $display("FAIL stall_hold got rs=%h rt=%h rd=%0d v=%b m=%b exp ab cd 10 1 0",
                        bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_valid, bus.ex_mem_read);
    end
    bus.flush = 1;
    step();
    n_vec++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_alu_op !== 4'h0) begin
      n_err++; $display("FAIL flush_stall got v=%b w=%b op=%h exp 0 0 0",
                        bus.ex_valid, bus.ex_reg_write, bus.ex_alu_op);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_immediate();
    id_instr(5'd1, 5'd2, 5'd6, 32'h1, 32'h2, 1, 0);
    step();
    id_instr(5'd0, 5'd6, 5'd13, 32'h0, 32'h999, 1, 0);
    bus.id_use_imm = 1; bus.id_imm = 32'hFFFFFFFC; bus.ex_result = 32'h5;
    bus.id_shamt = 5'd19; bus.id_alu_op = 4'h9;
    step();
    n_vec++;
    if (bus.ex_rt !== 32'hFFFFFFFC || bus.ex_store_data !== 32'h5) begin
      n_err++; $display("FAIL imm got rt=%h sd=%h exp fffffffc 00000005",
                        bus.ex_rt, bus.ex_store_data);
    end
    n_vec++;
    if (bus.ex_shamt !== 5'd19 || bus.ex_alu_op !== 4'h9) begin
      n_err++; $display("FAIL imm_ctl got sh=%0d op=%h exp 19 9", bus.ex_shamt, bus.ex_alu_op);
    end
    // invalid slot gates control bits
    bus.id_valid = 0;
    step();
    n_vec++;
    if (bus.ex_reg_write !== 1'b0 || bus.ex_alu_op !== 4'h0 || bus.ex_valid !== 1'b0) begin
      n_err++; $display("FAIL gate got w=%b op=%h v=%b exp 0 0 0",
                        bus.ex_reg_write, bus.ex_alu_op, bus.ex_valid);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_async_reset();
    id_instr(5'd1, 5'd2, 5'd14, 32'h44, 32'h55, 1, 0);
    step();
    #2;
    rst = 1;
    #1;
    n_vec++;
    if (bus.ex_valid !== 1'b0 || bus.ex_rs !== 32'h0 || bus.ex_rd !== 5'd0) begin
      n_err++; $display("FAIL async_rst got v=%b rs=%h rd=%0d exp 0 0 0",
                        bus.ex_valid, bus.ex_rs, bus.ex_rd);
    end
    @(negedge clk);
    rst = 0;
    step();
    n_vec++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rs !== 32'h44 || bus.ex_rd !== 5'd14) begin
      n_err++; $display("FAIL post_rst got v=%b rs=%h rd=%0d exp 1 44 14",
                        bus.ex_valid, bus.ex_rs, bus.ex_rd);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 0;
    idle_inputs();
    #1;
    test_reset();
    test_ex_forward();
    test_priority();
    test_zero_reg();
    test_load_use();
    test_stall_flush();
    test_immediate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
